// File: rtl/acc_seq_ctrl.sv
// rtl/acc_seq_ctrl.sv - C = A*B sequencer: bank indices, MAC strobes, C writes, completion status
// Busy/stall performance counters are built only when ACC_SEQ_PERF_EN is defined.
module acc_seq_ctrl #(
  parameter int DIM_MAX = 32,
  parameter int IDX_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       n_dim,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             irq,
  input  logic             dp_ready,
  output logic [IDX_W-1:0] a_idx,
  output logic [IDX_W-1:0] b_idx,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [IDX_W-1:0] c_idx,
  output logic             c_we,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls
);

  localparam int         CW    = IDX_W / 2;
  localparam logic [5:0] N_MAX = 6'(DIM_MAX);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MAC, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [5:0]    n_q, n_d;
  logic          done_q, done_d, err_q, err_d;
  logic          start_ok, k_last, j_last, i_last;

  assign start_ok = start && (n_dim != 6'd0) && (n_dim <= N_MAX);
  assign k_last   = 6'(k_q) == (n_q - 6'd1);
  assign j_last   = 6'(j_q) == (n_q - 6'd1);
  assign i_last   = 6'(i_q) == (n_q - 6'd1);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    n_d     = n_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          n_d     = n_dim;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_CLEAR;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_CLEAR: state_d = S_MAC;
      S_MAC: begin
        if (dp_ready) begin
          if (k_last) begin
            k_d     = '0;
            state_d = S_WRITE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (j_last && i_last) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (j_last) begin
          j_d     = '0;
          i_d     = i_q + 1'b1;
          state_d = S_CLEAR;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort drops the job without touching the completion flag.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = done_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      n_q     <= n_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy    = state_q != S_IDLE;
  assign mac_clr = state_q == S_CLEAR;
  assign mac_en  = (state_q == S_MAC) && dp_ready;
  assign c_we    = state_q == S_WRITE;
  assign irq     = state_q == S_DONE;
  assign done    = done_q;
  assign err     = err_q;
  // Row stride is DIM_MAX = 2**CW, so row*DIM_MAX+col is a plain concatenation.
  assign a_idx   = {i_q, k_q};
  assign b_idx   = {k_q, j_q};
  assign c_idx   = {i_q, j_q};

`ifdef ACC_SEQ_PERF_EN
  logic [31:0] cyc_q, stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else if (state_q == S_IDLE && start_ok) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (busy && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
      if (state_q == S_MAC && !dp_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stalls = stall_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule
